boron_inv_sbox_layer: RTL and testbench
=======================================

# boron_inv_sbox_layer

Inverse substitution layer for the Boron decryption datapath: undoes the 64-bit forward S-box layer by applying the 4-bit inverse Boron S-box to all 16 nibbles of a block. It is nibble-serial with a configurable number of nibbles per cycle, trading area for latency. It sits between the inverse permutation stage and the round-key XOR in the decryption round, behind a valid/ready handshake on both sides.

## Interface
- NIB_PER_CYC, 4, nibbles substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream block valid
- in_ready  output  1  block can be accepted this cycle
- in_data  input  64  ciphertext-side block; nibble i = bits [4i+3:4i]
- out_valid  output  1  out_data holds a finished block
- out_ready  input  1  downstream accepts out_data
- out_data  output  64  inverse-substituted block, nibble i = INV_SBOX(in_data nibble i)
- busy  output  1  high in RUN and DONE

## Operation
- Inverse S-box, nibble x -> value, for x = 0..F: A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B; forward of each value returns x, with the forward table being E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
- P = 16 / NIB_PER_CYC processing cycles per block.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1 (when rst = 0). On in_valid && in_ready: load in_data into 64-bit work register, cnt <= 0, go to RUN.
- RUN: each cycle, substitute the low NIB_PER_CYC nibbles of the work register, then rotate the register right by 4*NIB_PER_CYC bits, with the substituted nibbles entering at the top. cnt increments. When cnt == P-1, go to DONE. After P rotations, totalling 64 bits, every nibble is back in its original position.
- DONE: out_valid = 1 and out_data = work register, both held stable until out_ready. On out_ready, if in_valid is also high, accept the new block directly into RUN (in_ready = out_ready in DONE). Otherwise go to IDLE.
- in_ready = !rst && (state == IDLE || (state == DONE && out_ready)).
- in_data is ignored outside an accepting handshake. in_valid in RUN is stalled (in_ready = 0).
- cnt is 5 bits wide and never exceeds P-1.
- Reset at any point, including mid-RUN or in DONE with out_ready low, discards the block with no partial output.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 64'h0, busy 0, cnt 0; in_ready 0 while rst is high.
- Latency: block accepted at edge k -> out_valid high after edge k+P. Examples: NIB_PER_CYC = 16 gives 1 cycle; NIB_PER_CYC = 4 gives 4 cycles; NIB_PER_CYC = 1 gives 16 cycles.
- Throughput: one block per P+1 cycles with out_ready held high, using back-to-back acceptance from DONE.
- out_data changes only on the DONE-entry edge. out_valid deasserts on the edge after the out handshake, unless a chained block re-enters DONE later.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready only in DONE.

## Structure
- Shared package/include boron_pkg holds:
  - BLOCK_W = 64 and NIB_W = 4
  - forward and inverse S-box tables as 16x4 constants
  - FSM state encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
- Sub-module boron_inv_sbox: combinational 4-bit inverse lookup. Instantiate NIB_PER_CYC copies in a generate loop on the low nibbles of the work register.
- Top level holds the FSM, cnt, work register, and rotate/merge logic.

## Test plan
- Reset, then in_data = 64'h0 with NIB_PER_CYC = 4 -> out_valid after 4 cycles, out_data = 64'hAAAA_AAAA_AAAA_AAAA.
- in_data = 64'h0123_4567_89AB_CDEF -> out_data = 64'hA39E_1DF4_C572_680B, checked for every legal NIB_PER_CYC, with latency 16, 8, 4, 2, 1 respectively.
- Round trip: 1000 random blocks through the forward 64-bit S-box layer then this block -> output equals the original. Also check that every inverse table entry composed with the forward table returns x.
- Backpressure: out_ready held low 10 cycles in DONE -> out_data and out_valid stable, in_ready 0. Releasing out_ready with in_valid high -> new block accepted on the same edge, next result after P more cycles.
- Reset asserted mid-RUN (cnt = 2, NIB_PER_CYC = 2) -> next cycle state IDLE, out_valid 0, out_data 0. The next block is processed correctly from scratch.
- in_valid high during RUN with changing in_data -> ignored; in_ready stays 0; result matches the originally accepted block.

Source files
------------

// File: rtl/boron_pkg.sv
// Shared constants for the Boron cipher datapath: block geometry, 4-bit S-box
// tables and the substitution-layer FSM encoding.
package boron_pkg;

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned NIB_W   = 4;

    // Index 15 is listed first so that TABLE[x] returns the entry for x.
    localparam logic [15:0][3:0] FWD_SBOX = {
        4'h6, 4'h3, 4'h5, 4'h8, 4'hF, 4'h0, 4'h2, 4'hD,
        4'hA, 4'hC, 4'h9, 4'h7, 4'h1, 4'hB, 4'h4, 4'hE
    };

    localparam logic [15:0][3:0] INV_SBOX = {
        4'hB, 4'h0, 4'h8, 4'h6, 4'h2, 4'h7, 4'h5, 4'hC,
        4'h4, 4'hF, 4'hD, 4'h1, 4'hE, 4'h9, 4'h3, 4'hA
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/boron_inv_sbox.sv
// Combinational 4-bit inverse Boron S-box lookup.
module boron_inv_sbox
    import boron_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [NIB_W-1:0] result
);

    always_comb begin
        result = INV_SBOX[nibble];
    end

endmodule

// File: rtl/boron_inv_sbox_layer.sv
// Nibble-serial inverse S-box layer: substitutes NIB_PER_CYC nibbles per cycle
// by rotating a 64-bit work register, with valid/ready on both sides.
module boron_inv_sbox_layer
    import boron_pkg::*;
#(
    parameter int unsigned NIB_PER_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    localparam int unsigned STEP_W = NIB_PER_CYC * NIB_W;
    localparam int unsigned P      = 16 / NIB_PER_CYC;
    localparam logic [4:0]  LAST   = 5'(P - 1);

    if (!(NIB_PER_CYC == 1 || NIB_PER_CYC == 2 || NIB_PER_CYC == 4 ||
          NIB_PER_CYC == 8 || NIB_PER_CYC == 16)) begin : g_bad_nib_per_cyc
        $error("boron_inv_sbox_layer: NIB_PER_CYC must be 1, 2, 4, 8 or 16");
    end

    state_t             state, state_nxt;
    logic [BLOCK_W-1:0] work, work_nxt;
    logic [4:0]         cnt, cnt_nxt;
    logic [STEP_W-1:0]  sub;
    logic [BLOCK_W-1:0] rotated;
    logic               load_out;

    for (genvar n = 0; n < NIB_PER_CYC; n++) begin : g_sbox
        boron_inv_sbox u_sbox (
            .nibble (work[n*NIB_W +: NIB_W]),
            .result (sub[n*NIB_W +: NIB_W])
        );
    end

    // Substituted low nibbles re-enter at the top; after P steps every nibble is home.
    if (STEP_W == BLOCK_W) begin : g_rot_full
        assign rotated = sub;
    end else begin : g_rot_part
        assign rotated = {sub, work[BLOCK_W-1:STEP_W]};
    end

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        load_out  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    work_nxt  = in_data;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                work_nxt = rotated;
                if (cnt == LAST) begin
                    load_out  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = !rst && out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        work_nxt  = in_data;
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // out_data is a separate register so it only moves on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            cnt   <= cnt_nxt;
            if (load_out) begin
                out_data <= rotated;
            end
        end
    end

endmodule

// File: tb/tb_boron_inv_sbox_layer.sv
// Scoreboard bench: one DUT per legal NIB_PER_CYC, driven in turn; per-instance
// monitors check result data and acceptance-to-valid latency.
module tb_boron_inv_sbox_layer;

    logic        clk = 1'b0;
    logic        rst_v       [5];
    logic        in_valid_v  [5];
    logic        in_ready_v  [5];
    logic [63:0] in_data_v   [5];
    logic        out_valid_v [5];
    logic        out_ready_v [5];
    logic [63:0] out_data_v  [5];
    logic        busy_v      [5];

    logic [63:0] exp_q [5][$];
    int unsigned acc_q [5][$];
    bit          seen  [5];

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    localparam logic [15:0][3:0] FWD = {
        4'h6, 4'h3, 4'h5, 4'h8, 4'hF, 4'h0, 4'h2, 4'hD,
        4'hA, 4'hC, 4'h9, 4'h7, 4'h1, 4'hB, 4'h4, 4'hE
    };

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_dut
        boron_inv_sbox_layer #(.NIB_PER_CYC(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst_v[g]),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .out_data  (out_data_v[g]),
            .busy      (busy_v[g])
        );

        always @(negedge clk) begin
            if (!rst_v[g]) begin
                if (out_valid_v[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    if (acc_q[g].size() == 0)
                        fail_event($sformatf("unexpected_out_npc%0d", 1 << g));
                    else
                        check($sformatf("latency_npc%0d", 1 << g),
                              64'(cyc - acc_q[g][0]), 64'(16 >> g));
                end
                if (out_valid_v[g] && out_ready_v[g]) begin
                    if (exp_q[g].size() == 0) begin
                        fail_event($sformatf("extra_out_npc%0d", 1 << g));
                    end else begin
                        check($sformatf("data_npc%0d", 1 << g), out_data_v[g], exp_q[g].pop_front());
                        void'(acc_q[g].pop_front());
                    end
                    seen[g] = 1'b0;
                end
            end
        end
    end

    function automatic logic [63:0] fwd_layer(input logic [63:0] d);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = FWD[d[4*n +: 4]];
        return r;
    endfunction

    task automatic do_reset(input int i);
        rst_v[i] = 1'b1;
        in_valid_v[i] = 1'b0;
        out_ready_v[i] = 1'b1;
        exp_q[i].delete();
        acc_q[i].delete();
        seen[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready_v[i]), 64'd0);
        check("rst_out_valid", 64'(out_valid_v[i]), 64'd0);
        check("rst_out_data", out_data_v[i], 64'd0);
        check("rst_busy", 64'(busy_v[i]), 64'd0);
        @(posedge clk); #1;
        rst_v[i] = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready_v[i]), 64'd1);
        @(posedge clk); #1;
    endtask

    // Returns #1 after the accepting edge with in_valid dropped.
    task automatic send(input int i, input logic [63:0] d, input logic [63:0] e);
        bit ok = 1'b0;
        in_data_v[i] = d;
        in_valid_v[i] = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready_v[i]) begin
                ok = 1'b1;
                exp_q[i].push_back(e);
                acc_q[i].push_back(cyc + 1);
                break;
            end
        end
        if (!ok) fail_event("send_timeout");
        @(posedge clk); #1;
        in_valid_v[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int w = 0;
        while (exp_q[i].size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", 64'(exp_q[i].size()), 64'd0);
        @(posedge clk); #1;
    endtask

    localparam logic [63:0] VEC_IN  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VEC_OUT = 64'hA39E_1DF4_C572_680B;
    localparam logic [63:0] TAB_IN  = 64'h6358_F02D_AC97_1B4E;
    localparam logic [63:0] TAB_OUT = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] SEQ_OUT = 64'hB086_275C_4FD1_E93A;

    initial begin
        for (int k = 0; k < 5; k++) begin
            rst_v[k] = 1'b1;
            in_valid_v[k] = 1'b0;
            out_ready_v[k] = 1'b1;
            in_data_v[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 5; k++) begin
            do_reset(k);
            send(k, VEC_IN, VEC_OUT);
            drain(k);
        end

        // NIB_PER_CYC = 4: zero block, full table walk, random round trip
        send(2, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA);
        drain(2);
        send(2, TAB_IN, TAB_OUT);
        for (int r = 0; r < 1000; r++) begin
            logic [63:0] orig;
            orig = {$urandom, $urandom};
            send(2, fwd_layer(orig), orig);
        end
        drain(2);

        // Backpressure in DONE with a pending block upstream
        out_ready_v[2] = 1'b0;
        send(2, VEC_IN, VEC_OUT);
        in_valid_v[2] = 1'b1;
        in_data_v[2] = 64'h0;
        begin
            bit got = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                @(negedge clk);
                got = out_valid_v[2];
            end
            if (!got) fail_event("bp_wait_valid");
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid_v[2]), 64'd1);
            check("bp_out_data", out_data_v[2], VEC_OUT);
            check("bp_in_ready", 64'(in_ready_v[2]), 64'd0);
        end
        @(posedge clk); #1;
        out_ready_v[2] = 1'b1;
        send(2, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA);
        drain(2);

        // in_valid with changing data during RUN must be ignored
        send(2, TAB_OUT, SEQ_OUT);
        for (int c = 0; c < 3; c++) begin
            in_valid_v[2] = 1'b1;
            in_data_v[2] = {$urandom, $urandom};
            @(negedge clk);
            check("run_in_ready", 64'(in_ready_v[2]), 64'd0);
            check("run_busy", 64'(busy_v[2]), 64'd1);
            @(posedge clk); #1;
        end
        in_valid_v[2] = 1'b0;
        drain(2);

        // NIB_PER_CYC = 2: reset mid-RUN at cnt == 2
        send(1, VEC_IN, VEC_OUT);
        @(posedge clk);
        @(posedge clk); #1;
        rst_v[1] = 1'b1;
        exp_q[1].delete();
        acc_q[1].delete();
        seen[1] = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready_v[1]), 64'd0);
        @(posedge clk); #1;
        rst_v[1] = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid_v[1]), 64'd0);
        check("midrst_out_data", out_data_v[1], 64'd0);
        check("midrst_busy", 64'(busy_v[1]), 64'd0);
        @(posedge clk); #1;
        send(1, TAB_IN, TAB_OUT);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
